// File: rtl/wb_dcdr_pkg.sv
// Shared types and constants for the Wishbone module decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wb_dcdr_pkg;

  localparam int MOD_W  = 4;
  localparam int RADR_W = 8;
  localparam int DW     = 16;

  localparam logic [MOD_W-1:0] BCAST_MOD   = 4'hF;
  localparam logic [DW-1:0]    ERR_DAT_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } dcdr_st_e;

  // Error counter never wraps: it sticks at all ones.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_mod_dcdr_if.sv
// Bus bundle between the USB-side Wishbone master, the decoder and its slaves.
// Latency: none (wires only).
// Backpressure: slaves stall via sl_ack_i; the master waits for ack_o.
interface wb_mod_dcdr_if #(
  parameter int NSLV = 8
);
  import wb_dcdr_pkg::*;

  logic [MOD_W+RADR_W-1:0] adr_i;
  logic [DW-1:0]           dat_i;
  logic [DW-1:0]           dat_o;
  logic                    we_i;
  logic                    stb_i;
  logic                    cyc_i;
  logic                    ack_o;
  logic                    sl_cyc_o;
  logic [NSLV-1:0]         sl_stb_o;
  logic                    sl_we_o;
  logic [RADR_W-1:0]       sl_adr_o;
  logic [DW-1:0]           sl_dat_o;
  logic [DW*NSLV-1:0]      sl_dat_i;
  logic [NSLV-1:0]         sl_ack_i;

  // Decoder view: a Wishbone slave upstream, a fan-out master downstream.
  modport slave (
    input  adr_i, dat_i, we_i, stb_i, cyc_i, sl_dat_i, sl_ack_i,
    output dat_o, ack_o, sl_cyc_o, sl_stb_o, sl_we_o, sl_adr_o, sl_dat_o
  );

  // Environment view: the upstream master together with the slave ports.
  modport master (
    output adr_i, dat_i, we_i, stb_i, cyc_i, sl_dat_i, sl_ack_i,
    input  dat_o, ack_o, sl_cyc_o, sl_stb_o, sl_we_o, sl_adr_o, sl_dat_o
  );

endinterface

// File: rtl/wb_dcdr_tmo.sv
// Slave response watchdog: counts cycles while enabled, flags TMO_CYC-1 reached.
// Latency: exp_o follows the registered count combinationally.
// Backpressure: none; the count holds once expired until cleared.
module wb_dcdr_tmo #(
  parameter int TMO_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);

  localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  logic [CW-1:0] cnt;

  assign exp_o = (cnt == CW'(TMO_CYC - 1));

  // Count cycles spent waiting on the slave; clear whenever not waiting.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i && !exp_o) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_mod_dcdr.sv
// Wishbone module decoder: adr[11:8] selects one of NSLV slaves, adr[7:0] passes through.
// Latency: 1 cycle to slave strobe, slave ack latency + 2 to ack_o; unknown module acks next cycle.
// Backpressure: holds the slave strobe until ack or TMO_CYC timeout; WB_DCDR_BCAST_EN adds module-F broadcast writes.
module wb_mod_dcdr
  import wb_dcdr_pkg::*;
#(
  parameter int          NSLV    = 8,
  parameter int          TMO_CYC = 64,
  parameter logic [15:0] ERR_DAT = ERR_DAT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  wb_mod_dcdr_if.slave    bus,
  output logic            busy_o,
  output logic [DW-1:0]   err_cnt_o
);

  dcdr_st_e          state;
  logic [NSLV-1:0]   sel_q;
  logic [NSLV-1:0]   stb_q;
  logic              cyc_q;
  logic              we_q;
  logic              ack_q;
  logic [RADR_W-1:0] adr_q;
  logic [DW-1:0]     wdat_q;
  logic [DW-1:0]     rdat_q;
  logic [DW-1:0]     err_q;

  logic [MOD_W-1:0]  req_mod;
  logic [NSLV-1:0]   req_hot;
  logic [DW-1:0]     sl_rdat;
  logic              ack_hit;
  logic              tmo_exp;

`ifdef WB_DCDR_BCAST_EN
  logic              bcast_q;
  logic [NSLV-1:0]   mask_q;
  logic [NSLV-1:0]   mask_nxt;
  assign mask_nxt = mask_q | bus.sl_ack_i;
`endif

  assign req_mod = bus.adr_i[RADR_W +: MOD_W];
  assign ack_hit = |(bus.sl_ack_i & sel_q);

  // One-hot decode of the requested module; out-of-range indices decode to zero.
  always_comb begin
    req_hot = '0;
    for (int k = 0; k < NSLV; k++) begin
      req_hot[k] = (req_mod == MOD_W'(k));
    end
  end

  // Read data mux driven by the latched selection.
  always_comb begin
    sl_rdat = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q[k]) sl_rdat = sl_rdat | bus.sl_dat_i[k*DW +: DW];
    end
  end

  wb_dcdr_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (state != ST_FWD),
    .en_i    (state == ST_FWD),
    .exp_o   (tmo_exp)
  );

  // Transaction FSM: accept, forward until ack/timeout/abort, then pulse ack_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= ST_IDLE;
      sel_q  <= '0;
      stb_q  <= '0;
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      ack_q  <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      err_q  <= '0;
`ifdef WB_DCDR_BCAST_EN
      bcast_q <= 1'b0;
      mask_q  <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cyc_i && bus.stb_i) begin
            adr_q  <= bus.adr_i[RADR_W-1:0];
            wdat_q <= bus.dat_i;
            we_q   <= bus.we_i;
            sel_q  <= req_hot;
`ifdef WB_DCDR_BCAST_EN
            bcast_q <= 1'b0;
            if (req_mod == BCAST_MOD && bus.we_i) begin
              bcast_q <= 1'b1;
              mask_q  <= '0;
              stb_q   <= '1;
              cyc_q   <= 1'b1;
              state   <= ST_FWD;
            end else
`endif
            if (|req_hot) begin
              stb_q <= req_hot;
              cyc_q <= 1'b1;
              state <= ST_FWD;
            end else begin
              rdat_q <= ERR_DAT;
              err_q  <= sat_inc(err_q);
              ack_q  <= 1'b1;
              state  <= ST_RESP;
            end
          end
        end
        ST_FWD: begin
          if (!bus.cyc_i) begin
            stb_q <= '0;
            cyc_q <= 1'b0;
            state <= ST_IDLE;
          end
`ifdef WB_DCDR_BCAST_EN
          else if (bcast_q) begin
            mask_q <= mask_nxt;
            stb_q  <= stb_q & ~bus.sl_ack_i;
            if (&mask_nxt) begin
              rdat_q <= '0;
              cyc_q  <= 1'b0;
              ack_q  <= 1'b1;
              state  <= ST_RESP;
            end else if (tmo_exp) begin
              stb_q  <= '0;
              cyc_q  <= 1'b0;
              rdat_q <= ERR_DAT;
              err_q  <= sat_inc(err_q);
              ack_q  <= 1'b1;
              state  <= ST_RESP;
            end
          end
`endif
          else if (ack_hit) begin
            rdat_q <= we_q ? '0 : sl_rdat;
            stb_q  <= '0;
            cyc_q  <= 1'b0;
            ack_q  <= 1'b1;
            state  <= ST_RESP;
          end else if (tmo_exp) begin
            stb_q  <= '0;
            cyc_q  <= 1'b0;
            rdat_q <= ERR_DAT;
            err_q  <= sat_inc(err_q);
            ack_q  <= 1'b1;
            state  <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dat_o    = rdat_q;
  assign bus.ack_o    = ack_q;
  assign bus.sl_cyc_o = cyc_q;
  assign bus.sl_stb_o = stb_q;
  assign bus.sl_we_o  = we_q;
  assign bus.sl_adr_o = adr_q;
  assign bus.sl_dat_o = wdat_q;
  assign busy_o       = (state != ST_IDLE);
  assign err_cnt_o    = err_q;

endmodule
